// File: rtl/cash_dispenser_ctrl.sv
// Bill-dispensing sequencer: greedy plan over four cassettes, one-bill-at-a-time
// req/ack handshake, inventory tracking, completion/error/jam reporting.
module cash_dispenser_ctrl #(
   parameter int unsigned DENOM0    = 20000,
   parameter int unsigned DENOM1    = 10000,
   parameter int unsigned DENOM2    = 5000,
   parameter int unsigned DENOM3    = 1000,
   parameter int unsigned INV_W     = 8,
   parameter int unsigned INV_INIT  = 100,
   parameter int unsigned MAX_MONTO = 400000,
   parameter int unsigned TIMEOUT   = 15
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        ENTREGAR_DINERO,
   input  logic [31:0] MONTO,
   input  logic        BILL_ACK,
   output logic        BILL_REQ,
   output logic [1:0]  BILL_SEL,
   output logic        BUSY,
   output logic        DONE,
   output logic        ERROR_MONTO,
   output logic        ATASCO,
   output logic [3:0]  INV_VACIO
);

   localparam int unsigned TMR_W = $clog2(TIMEOUT + 1);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_PLAN = 3'd1;
   localparam logic [2:0] S_REQ  = 3'd2;
   localparam logic [2:0] S_GAP  = 3'd3;
   localparam logic [2:0] S_FIN  = 3'd4;
   localparam logic [2:0] S_ERR  = 3'd5;
   localparam logic [2:0] S_JAM  = 3'd6;

   logic [2:0]       state_q, state_d;
   logic [31:0]      rem_q, rem_d;
   logic [1:0]       idx_q, idx_d;
   logic [TMR_W-1:0] timer_q, timer_d;
   logic [INV_W-1:0] n_q [4];
   logic [INV_W-1:0] n_d [4];
   logic [INV_W-1:0] inv_q [4];
   logic [INV_W-1:0] inv_d [4];

   logic       req_d, busy_d, done_d, err_d, atasco_d;
   logic [1:0] sel_d;
   logic [3:0] vacio_d;
   logic       any_left;

   function automatic logic [31:0] denom_of(input logic [1:0] i);
      case (i)
         2'd0:    denom_of = 32'(DENOM0);
         2'd1:    denom_of = 32'(DENOM1);
         2'd2:    denom_of = 32'(DENOM2);
         default: denom_of = 32'(DENOM3);
      endcase
   endfunction

   // Next-state, datapath and registered-output values
   always_comb begin
      state_d  = state_q;
      rem_d    = rem_q;
      idx_d    = idx_q;
      timer_d  = timer_q;
      n_d      = n_q;
      inv_d    = inv_q;
      any_left = (n_q[0] != '0) || (n_q[1] != '0) || (n_q[2] != '0) || (n_q[3] != '0);

      case (state_q)
         S_IDLE: begin
            if (ENTREGAR_DINERO) begin
               rem_d = MONTO;
               if ((MONTO == 32'd0) || (MONTO > 32'(MAX_MONTO)) ||
                   ((MONTO % 32'(DENOM3)) != 32'd0)) begin
                  state_d = S_ERR;
               end else begin
                  for (int i = 0; i < 4; i++) n_d[i] = '0;
                  idx_d   = 2'd0;
                  state_d = S_PLAN;
               end
            end
         end
         S_PLAN: begin
            timer_d = '0;
            if ((rem_q >= denom_of(idx_q)) && (n_q[idx_q] < inv_q[idx_q])) begin
               n_d[idx_q] = n_q[idx_q] + INV_W'(1);
               rem_d      = rem_q - denom_of(idx_q);
            end else if (idx_q != 2'd3) begin
               idx_d = idx_q + 2'd1;
            end else begin
               state_d = (rem_q == 32'd0) ? S_REQ : S_ERR;
            end
         end
         S_REQ: begin
            // An ack on the expiry cycle still counts as a delivered bill
            if (BILL_ACK) begin
               inv_d[BILL_SEL] = inv_q[BILL_SEL] - INV_W'(1);
               n_d[BILL_SEL]   = n_q[BILL_SEL] - INV_W'(1);
               state_d         = S_GAP;
            end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
               state_d = S_JAM;
            end else begin
               timer_d = timer_q + TMR_W'(1);
            end
         end
         S_GAP: begin
            timer_d = '0;
            state_d = any_left ? S_REQ : S_FIN;
         end
         S_FIN:   state_d = S_IDLE;
         S_ERR:   state_d = S_IDLE;
         S_JAM:   state_d = S_JAM;
         default: state_d = S_IDLE;
      endcase

      req_d    = (state_d == S_REQ);
      busy_d   = (state_d != S_IDLE) && (state_d != S_JAM);
      done_d   = (state_d == S_FIN);
      err_d    = (state_d == S_ERR);
      atasco_d = (state_d == S_JAM);

      sel_d = BILL_SEL;
      if (state_d == S_REQ) begin
         if (n_d[0] != '0)      sel_d = 2'd0;
         else if (n_d[1] != '0) sel_d = 2'd1;
         else if (n_d[2] != '0) sel_d = 2'd2;
         else                   sel_d = 2'd3;
      end

      // Flags lag the inventory register by one cycle
      vacio_d = '0;
      for (int i = 0; i < 4; i++) vacio_d[i] = (inv_q[i] == '0);
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q     <= S_IDLE;
         rem_q       <= '0;
         idx_q       <= '0;
         timer_q     <= '0;
         for (int i = 0; i < 4; i++) begin
            n_q[i]   <= '0;
            inv_q[i] <= INV_W'(INV_INIT);
         end
         BILL_REQ    <= 1'b0;
         BILL_SEL    <= 2'd0;
         BUSY        <= 1'b0;
         DONE        <= 1'b0;
         ERROR_MONTO <= 1'b0;
         ATASCO      <= 1'b0;
         INV_VACIO   <= {4{INV_INIT == 0}};
      end else begin
         state_q     <= state_d;
         rem_q       <= rem_d;
         idx_q       <= idx_d;
         timer_q     <= timer_d;
         n_q         <= n_d;
         inv_q       <= inv_d;
         BILL_REQ    <= req_d;
         BILL_SEL    <= sel_d;
         BUSY        <= busy_d;
         DONE        <= done_d;
         ERROR_MONTO <= err_d;
         ATASCO      <= atasco_d;
         INV_VACIO   <= vacio_d;
      end
   end

endmodule

// File: tb/tb_cash_dispenser_ctrl.sv
// Directed bench for cash_dispenser_ctrl: default instance plus a 2-bill-per-cassette instance.
module tb_cash_dispenser_ctrl;

   logic CLK = 1'b0;
   always #5 CLK = ~CLK;

   logic        rst_a, start_a, ack_a, rst_b, start_b, ack_b;
   logic [31:0] monto_a, monto_b;
   logic        req_a, busy_a, done_a, err_a, jam_a;
   logic        req_b, busy_b, done_b, err_b, jam_b;
   logic [1:0]  sel_a, sel_b;
   logic [3:0]  vac_a, vac_b;

   int n_cmp = 0;
   int n_bad = 0;

   cash_dispenser_ctrl dut_a (
      .CLK(CLK), .RESET(rst_a), .ENTREGAR_DINERO(start_a), .MONTO(monto_a), .BILL_ACK(ack_a),
      .BILL_REQ(req_a), .BILL_SEL(sel_a), .BUSY(busy_a), .DONE(done_a),
      .ERROR_MONTO(err_a), .ATASCO(jam_a), .INV_VACIO(vac_a));

   cash_dispenser_ctrl #(.INV_INIT(2)) dut_b (
      .CLK(CLK), .RESET(rst_b), .ENTREGAR_DINERO(start_b), .MONTO(monto_b), .BILL_ACK(ack_b),
      .BILL_REQ(req_b), .BILL_SEL(sel_b), .BUSY(busy_b), .DONE(done_b),
      .ERROR_MONTO(err_b), .ATASCO(jam_b), .INV_VACIO(vac_b));

   task automatic set_start(input bit which, input logic s, input logic [31:0] m);
      if (which) begin start_b = s; monto_b = m; end
      else       begin start_a = s; monto_a = m; end
   endtask

   task automatic set_ack(input bit which, input logic a);
      if (which) ack_b = a; else ack_a = a;
   endtask

   task automatic set_rst(input bit which, input logic r);
      if (which) rst_b = r; else rst_a = r;
   endtask

   task automatic do_reset(input bit which);
      @(negedge CLK); set_rst(which, 1'b1);
      @(negedge CLK);
      @(negedge CLK); set_rst(which, 1'b0);
   endtask

   // Runs one withdrawal; records the cassette of each bill and handshake shape
   task automatic run(input bit which, input logic [31:0] m, input int ack_dly,
                      input bit inject, input int abort_bill,
                      output int nbills, output logic [15:0] seq, output bit done,
                      output bit err, output bit jam, output bit gap_ok,
                      output int lat, output int req_len);
      int lowrun, rc;
      bit prev, had;
      logic r, d, e, j;
      logic [1:0] s, last_s;
      nbills = 0; seq = '0; done = 0; err = 0; jam = 0; gap_ok = 1; lat = -1; req_len = 0;
      lowrun = 0; rc = 0; prev = 0; had = 0; last_s = 2'd0;
      @(negedge CLK); set_start(which, 1'b1, m);
      @(negedge CLK); set_start(which, 1'b0, 32'hDEAD_BEEF);
      for (int c = 0; c < 600; c++) begin
         r = which ? req_b  : req_a;
         s = which ? sel_b  : sel_a;
         d = which ? done_b : done_a;
         e = which ? err_b  : err_a;
         j = which ? jam_b  : jam_a;
         if (d) begin done = 1; lat = c; break; end
         if (e) begin err = 1; lat = c; break; end
         if (j) begin jam = 1; lat = c; break; end
         if (r) begin
            set_start(which, 1'b0, 32'h0);
            if (!prev) begin
               if (had && lowrun != 1) gap_ok = 0;
               if (nbills < 8) seq[2*nbills +: 2] = s;
               nbills++;
               had = 1;
               rc = 0;
               if (nbills == abort_bill) begin set_rst(which, 1'b1); lat = c; break; end
            end else if (s !== last_s) begin
               gap_ok = 0;
            end
            last_s = s;
            rc++;
            req_len = rc;
            set_ack(which, rc == ack_dly);
            lowrun = 0;
         end else begin
            lowrun++;
            set_ack(which, inject && had);
            if (inject && had) set_start(which, 1'b1, 32'd1000);
            else               set_start(which, 1'b0, 32'h0);
         end
         prev = r;
         @(negedge CLK);
      end
      set_ack(which, 1'b0);
      set_start(which, 1'b0, 32'h0);
   endtask

   task automatic test_reset;
      @(negedge CLK);
      @(negedge CLK);
      n_cmp++;
      if ({req_a, sel_a, busy_a, done_a, err_a, jam_a, vac_a} !== 11'd0) begin
         n_bad++; $display("FAIL reset_outputs: got %b want 0", {req_a, sel_a, busy_a, done_a, err_a, jam_a, vac_a});
      end
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (dut_a.inv_q[i] !== 8'd100) begin
            n_bad++; $display("FAIL reset_inv%0d: got %0d want 100", i, dut_a.inv_q[i]);
         end
      end
      n_cmp++;
      if (dut_b.inv_q[3] !== 8'd2 || vac_b !== 4'd0) begin
         n_bad++; $display("FAIL reset_b: got inv3=%0d vac=%b want 2 0000", dut_b.inv_q[3], vac_b);
      end
      rst_a = 1'b0; rst_b = 1'b0;
   endtask

   task automatic test_dispense;
      int nb, lat, rl; logic [15:0] sq; bit dn, er, jm, gok;
      do_reset(0);
      run(0, 32'd36000, 2, 0, -1, nb, sq, dn, er, jm, gok, lat, rl);
      n_cmp++;
      if (!dn || nb != 4 || sq !== 16'hE4) begin
         n_bad++; $display("FAIL disp_36000: got done=%0d bills=%0d seq=%h want 1 4 00e4", dn, nb, sq);
      end
      n_cmp++;
      if (!gok || lat != 20) begin
         n_bad++; $display("FAIL disp_timing: got gap_ok=%0d done_at=%0d want 1 20", gok, lat);
      end
      for (int i = 0; i < 4; i++) begin
         n_cmp++;
         if (dut_a.inv_q[i] !== 8'd99) begin
            n_bad++; $display("FAIL disp_inv%0d: got %0d want 99", i, dut_a.inv_q[i]);
         end
      end
      @(negedge CLK);
      n_cmp++;
      if (done_a !== 1'b0 || busy_a !== 1'b0 || vac_a !== 4'd0) begin
         n_bad++; $display("FAIL done_pulse: got done=%b busy=%b vac=%b want 0 0 0000", done_a, busy_a, vac_a);
      end
   endtask

   task automatic test_bad_monto;
      int nb, lat, rl; logic [15:0] sq; bit dn, er, jm, gok;
      logic [31:0] bad [3];
      bad[0] = 32'd2500; bad[1] = 32'd0; bad[2] = 32'd401000;
      for (int k = 0; k < 3; k++) begin
         run(0, bad[k], 1, 0, -1, nb, sq, dn, er, jm, gok, lat, rl);
         n_cmp++;
         if (!er || dn || nb != 0 || lat != 0) begin
            n_bad++; $display("FAIL bad_monto_%0d: got err=%0d done=%0d bills=%0d at=%0d want 1 0 0 0", bad[k], er, dn, nb, lat);
         end
      end
      do_reset(0);
      run(0, 32'd400000, 1, 0, -1, nb, sq, dn, er, jm, gok, lat, rl);
      n_cmp++;
      if (!dn || nb != 20 || sq !== 16'h0000 || dut_a.inv_q[0] !== 8'd80) begin
         n_bad++; $display("FAIL max_monto: got done=%0d bills=%0d seq=%h inv0=%0d want 1 20 0000 80", dn, nb, sq, dut_a.inv_q[0]);
      end
   endtask

   task automatic test_inventory;
      int nb, lat, rl; logic [15:0] sq; bit dn, er, jm, gok;
      do_reset(1);
      run(1, 32'd60000, 1, 0, -1, nb, sq, dn, er, jm, gok, lat, rl);
      @(negedge CLK);
      n_cmp++;
      if (!dn || nb != 4 || sq !== 16'h0050 || vac_b !== 4'b0011) begin
         n_bad++; $display("FAIL inv_60000: got done=%0d bills=%0d seq=%h vac=%b want 1 4 0050 0011", dn, nb, sq, vac_b);
      end
      run(1, 32'd20000, 1, 0, -1, nb, sq, dn, er, jm, gok, lat, rl);
      @(negedge CLK);
      n_cmp++;
      if (!er || nb != 0 || lat != 8 || vac_b !== 4'b0011) begin
         n_bad++; $display("FAIL inv_short: got err=%0d bills=%0d at=%0d vac=%b want 1 0 8 0011", er, nb, lat, vac_b);
      end
      run(1, 32'd12000, 1, 0, -1, nb, sq, dn, er, jm, gok, lat, rl);
      @(negedge CLK);
      n_cmp++;
      if (!dn || nb != 4 || sq !== 16'h00FA || vac_b !== 4'b1111) begin
         n_bad++; $display("FAIL inv_12000: got done=%0d bills=%0d seq=%h vac=%b want 1 4 00fa 1111", dn, nb, sq, vac_b);
      end
      run(1, 32'd1000, 1, 0, -1, nb, sq, dn, er, jm, gok, lat, rl);
      n_cmp++;
      if (!er || nb != 0 || lat != 4) begin
         n_bad++; $display("FAIL inv_empty: got err=%0d bills=%0d at=%0d want 1 0 4", er, nb, lat);
      end
   endtask

   task automatic test_jam;
      int nb, lat, rl; logic [15:0] sq; bit dn, er, jm, gok;
      do_reset(0);
      run(0, 32'd20000, 0, 0, -1, nb, sq, dn, er, jm, gok, lat, rl);
      n_cmp++;
      if (!jm || nb != 1 || rl != 15 || req_a !== 1'b0 || busy_a !== 1'b0) begin
         n_bad++; $display("FAIL jam_entry: got jam=%0d bills=%0d req_len=%0d req=%b busy=%b want 1 1 15 0 0", jm, nb, rl, req_a, busy_a);
      end
      start_a = 1'b1; monto_a = 32'd1000; ack_a = 1'b1;
      @(negedge CLK); start_a = 1'b0; ack_a = 1'b0;
      repeat (5) @(negedge CLK);
      n_cmp++;
      if (jam_a !== 1'b1 || req_a !== 1'b0 || busy_a !== 1'b0 || dut_a.inv_q[0] !== 8'd100) begin
         n_bad++; $display("FAIL jam_hold: got atasco=%b req=%b busy=%b inv0=%0d want 1 0 0 100", jam_a, req_a, busy_a, dut_a.inv_q[0]);
      end
      do_reset(0);
      n_cmp++;
      if (jam_a !== 1'b0) begin
         n_bad++; $display("FAIL jam_clear: got %b want 0", jam_a);
      end
      run(0, 32'd1000, 15, 0, -1, nb, sq, dn, er, jm, gok, lat, rl);
      n_cmp++;
      if (!dn || jm || rl != 15 || dut_a.inv_q[3] !== 8'd99) begin
         n_bad++; $display("FAIL ack_at_expiry: got done=%0d jam=%0d req_len=%0d inv3=%0d want 1 0 15 99", dn, jm, rl, dut_a.inv_q[3]);
      end
   endtask

   task automatic test_reset_mid;
      int nb, lat, rl; logic [15:0] sq; bit dn, er, jm, gok;
      do_reset(0);
      run(0, 32'd30000, 1, 0, 2, nb, sq, dn, er, jm, gok, lat, rl);
      @(negedge CLK);
      n_cmp++;
      if ({req_a, sel_a, busy_a, done_a, err_a, jam_a, vac_a} !== 11'd0 ||
          dut_a.inv_q[0] !== 8'd100 || dut_a.inv_q[1] !== 8'd100) begin
         n_bad++; $display("FAIL reset_mid: got out=%b inv0=%0d inv1=%0d want 0 100 100",
            {req_a, sel_a, busy_a, done_a, err_a, jam_a, vac_a}, dut_a.inv_q[0], dut_a.inv_q[1]);
      end
      rst_a = 1'b0;
      run(0, 32'd1000, 1, 0, -1, nb, sq, dn, er, jm, gok, lat, rl);
      n_cmp++;
      if (!dn || nb != 1 || sq !== 16'h0003 || dut_a.inv_q[3] !== 8'd99) begin
         n_bad++; $display("FAIL after_reset_mid: got done=%0d bills=%0d seq=%h inv3=%0d want 1 1 0003 99", dn, nb, sq, dut_a.inv_q[3]);
      end
   endtask

   task automatic test_ignored_inputs;
      int nb, lat, rl; logic [15:0] sq; bit dn, er, jm, gok;
      do_reset(0);
      run(0, 32'd36000, 1, 1, -1, nb, sq, dn, er, jm, gok, lat, rl);
      n_cmp++;
      if (!dn || nb != 4 || sq !== 16'hE4 || !gok) begin
         n_bad++; $display("FAIL ignore_inj: got done=%0d bills=%0d seq=%h gap_ok=%0d want 1 4 00e4 1", dn, nb, sq, gok);
      end
      n_cmp++;
      if (dut_a.inv_q[0] !== 8'd99 || dut_a.inv_q[3] !== 8'd99) begin
         n_bad++; $display("FAIL ignore_inv: got inv0=%0d inv3=%0d want 99 99", dut_a.inv_q[0], dut_a.inv_q[3]);
      end
   endtask

   task automatic test_back_to_back;
      int nb, lat, rl; logic [15:0] sq; bit dn, er, jm, gok;
      bit dn1;
      run(0, 32'd1000, 1, 0, -1, nb, sq, dn1, er, jm, gok, lat, rl);
      run(0, 32'd2000, 1, 0, -1, nb, sq, dn, er, jm, gok, lat, rl);
      n_cmp++;
      if (!dn1 || !dn || nb != 2 || sq !== 16'h000F || dut_a.inv_q[3] !== 8'd96) begin
         n_bad++; $display("FAIL back_to_back: got done=%0d/%0d bills=%0d seq=%h inv3=%0d want 1/1 2 000f 96", dn1, dn, nb, sq, dut_a.inv_q[3]);
      end
   endtask

   initial begin
      rst_a = 1'b1; rst_b = 1'b1;
      start_a = 1'b0; start_b = 1'b0; ack_a = 1'b0; ack_b = 1'b0;
      monto_a = 32'd0; monto_b = 32'd0;
      test_reset();
      test_dispense();
      test_bad_monto();
      test_inventory();
      test_jam();
      test_reset_mid();
      test_ignored_inputs();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
